// File: rtl/adder_sched_pkg.sv
// Shared definitions for the round-robin adder scheduler: FSM encoding and
// the width of the completed-transaction counter.
package adder_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int TXN_CNT_W = 16;

endpackage

// File: rtl/adder.sv
// Unsigned adder with carry-out in the result MSB, so no overflow is possible.
module adder #(
  parameter int C_DATA_WIDTH = 4
) (
  input  logic [C_DATA_WIDTH-1:0] I_a,
  input  logic [C_DATA_WIDTH-1:0] I_b,
  output logic [C_DATA_WIDTH:0]   O_sum
);

  assign O_sum = {1'b0, I_a} + {1'b0, I_b};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin winner search: the first asserted request at or after the
// pointer (wrapping) receives a one-hot grant.
module rr_arbiter #(
  parameter int C_REQ_NUM  = 4,
  parameter int C_ID_WIDTH = 2
) (
  input  logic [C_REQ_NUM-1:0]  I_req,
  input  logic [C_ID_WIDTH-1:0] I_ptr,
  output logic [C_REQ_NUM-1:0]  O_grant
);

  logic [2*C_REQ_NUM-1:0] dbl_req;
  logic [2*C_REQ_NUM-1:0] dbl_grant;
  logic [C_REQ_NUM-1:0]   rot_req;
  logic [C_REQ_NUM-1:0]   rot_grant;

  // Rotate so the pointer position becomes bit 0, isolate the lowest set bit,
  // then rotate the grant back into requester order.
  assign dbl_req   = {I_req, I_req} >> I_ptr;
  assign rot_req   = dbl_req[C_REQ_NUM-1:0];
  assign rot_grant = rot_req & (~rot_req + C_REQ_NUM'(1));
  assign dbl_grant = {rot_grant, rot_grant} << I_ptr;
  assign O_grant   = dbl_grant[2*C_REQ_NUM-1:C_REQ_NUM];

endmodule

// File: rtl/adder_rr_sched.sv
// Shares one adder among C_REQ_NUM requesters: round-robin accept in IDLE,
// registered sum in EXEC, response held in RESP until the downstream takes it.
module adder_rr_sched
  import adder_sched_pkg::*;
#(
  parameter int C_DATA_WIDTH = 4,
  parameter int C_REQ_NUM    = 4,
  parameter int C_ID_WIDTH   = 2
) (
  input  logic                            I_sys_clk,
  input  logic                            I_rst,
  input  logic [C_REQ_NUM-1:0]            I_req_valid,
  output logic [C_REQ_NUM-1:0]            O_req_ready,
  input  logic [C_REQ_NUM*C_DATA_WIDTH-1:0] I_req_a,
  input  logic [C_REQ_NUM*C_DATA_WIDTH-1:0] I_req_b,
  output logic                            O_rsp_valid,
  input  logic                            I_rsp_ready,
  output logic [C_DATA_WIDTH:0]           O_rsp_sum,
  output logic [C_ID_WIDTH-1:0]           O_rsp_id,
  output logic                            O_busy,
  output logic [TXN_CNT_W-1:0]            O_txn_cnt
);

  localparam int W = C_DATA_WIDTH;

  state_e                state_q, state_d;
  logic [C_ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [C_ID_WIDTH-1:0] cap_id_q, cap_id_d;
  logic [W-1:0]          cap_a_q, cap_a_d;
  logic [W-1:0]          cap_b_q, cap_b_d;
  logic [W:0]            sum_q, sum_d;
  logic [C_ID_WIDTH-1:0] rsp_id_q, rsp_id_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [TXN_CNT_W-1:0]  txn_cnt_q, txn_cnt_d;

  logic [C_REQ_NUM-1:0]  grant;
  logic [C_ID_WIDTH-1:0] win_id;
  logic [W-1:0]          win_a;
  logic [W-1:0]          win_b;
  logic [W:0]            add_sum;
  logic                  accept;

  rr_arbiter #(
    .C_REQ_NUM  (C_REQ_NUM),
    .C_ID_WIDTH (C_ID_WIDTH)
  ) u_arb (
    .I_req   (I_req_valid),
    .I_ptr   (ptr_q),
    .O_grant (grant)
  );

  adder #(
    .C_DATA_WIDTH (C_DATA_WIDTH)
  ) u_add (
    .I_a   (cap_a_q),
    .I_b   (cap_b_q),
    .O_sum (add_sum)
  );

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    win_id = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < C_REQ_NUM; i++) begin
      if (grant[i]) begin
        win_id = C_ID_WIDTH'(i);
        win_a  = I_req_a[i*W +: W];
        win_b  = I_req_b[i*W +: W];
      end
    end
  end

  // Ready is suppressed while reset is asserted so nothing is offered then.
  assign accept      = (state_q == ST_IDLE) && !I_rst && (|grant);
  assign O_req_ready = accept ? grant : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cap_id_d    = cap_id_q;
    cap_a_d     = cap_a_q;
    cap_b_d     = cap_b_q;
    sum_d       = sum_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    txn_cnt_d   = txn_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_EXEC;
          cap_id_d = win_id;
          cap_a_d  = win_a;
          cap_b_d  = win_b;
          ptr_d    = (win_id == C_ID_WIDTH'(C_REQ_NUM - 1)) ? '0
                                                             : win_id + C_ID_WIDTH'(1);
        end
      end
      ST_EXEC: begin
        state_d     = ST_RESP;
        sum_d       = add_sum;
        rsp_id_d    = cap_id_q;
        rsp_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (I_rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          txn_cnt_d   = txn_cnt_q + TXN_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cap_id_q    <= '0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      sum_q       <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      txn_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cap_id_q    <= cap_id_d;
      cap_a_q     <= cap_a_d;
      cap_b_q     <= cap_b_d;
      sum_q       <= sum_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      txn_cnt_q   <= txn_cnt_d;
    end
  end

  assign O_rsp_valid = rsp_valid_q;
  assign O_rsp_sum   = sum_q;
  assign O_rsp_id    = rsp_id_q;
  assign O_busy      = (state_q != ST_IDLE);
  assign O_txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed bench for adder_rr_sched: inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_adder_rr_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_sum;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [15:0] txn_cnt;

  int tests_run;
  int tests_failed;
  logic [15:0] exp_cnt;

  adder_rr_sched #(
    .C_DATA_WIDTH (4),
    .C_REQ_NUM    (4),
    .C_ID_WIDTH   (2)
  ) dut (
    .I_sys_clk   (clk),
    .I_rst       (rst),
    .I_req_valid (req_valid),
    .O_req_ready (req_ready),
    .I_req_a     (req_a),
    .I_req_b     (req_b),
    .O_rsp_valid (rsp_valid),
    .I_rsp_ready (rsp_ready),
    .O_rsp_sum   (rsp_sum),
    .O_rsp_id    (rsp_id),
    .O_busy      (busy),
    .O_txn_cnt   (txn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int k, input logic [3:0] a, input logic [3:0] b);
    req_valid[k]     = 1'b1;
    req_a[k*4 +: 4]  = a;
    req_b[k*4 +: 4]  = b;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    @(negedge clk); #1;
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    tests_run++;
    if ({rsp_valid, busy, rsp_sum, rsp_id, txn_cnt} !== 25'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b busy=%b sum=%h id=%0d cnt=%h expected all zero",
               rsp_valid, busy, rsp_sum, rsp_id, txn_cnt);
    end
    req_valid = 4'h0;
    rst       = 1'b0;
    exp_cnt   = 16'd0;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(0, 4'd3, 4'd4);
    rsp_ready = 1'b1; #1;
    tests_run++;
    if (req_ready !== 4'b0001 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_accept: got ready=%b busy=%b expected ready=0001 busy=0", req_ready, busy);
    end
    @(negedge clk);
    req_valid = 4'h0; #1;
    tests_run++;
    if (req_ready !== 4'b0000 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_exec: got ready=%b busy=%b valid=%b expected 0000/1/0", req_ready, busy, rsp_valid);
    end
    @(negedge clk); #1;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 5'h07 || rsp_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL single_rsp: got valid=%b sum=%h id=%0d expected 1/07/0", rsp_valid, rsp_sum, rsp_id);
    end
    @(negedge clk); #1;
    exp_cnt++;
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || txn_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL single_done: got valid=%b busy=%b cnt=%0d expected 0/0/1", rsp_valid, busy, txn_cnt);
    end
  endtask

  task automatic test_max_operands();
    @(negedge clk);
    set_req(0, 4'hF, 4'hF);
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk); #1;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 5'h1E || rsp_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL max_sum: got valid=%b sum=%h id=%0d expected 1/1e/0", rsp_valid, rsp_sum, rsp_id);
    end
    @(negedge clk);
    exp_cnt++;
  endtask

  task automatic test_fairness();
    int         g_cyc[$];
    logic [3:0] g_vec[$];
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    exp_cnt   = 16'd0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) set_req(k, 4'(k), 4'(k + 1));
    for (int c = 0; c < 13; c++) begin
      #1;
      if (req_ready !== 4'b0000) begin
        g_cyc.push_back(c);
        g_vec.push_back(req_ready);
      end
      @(negedge clk);
    end
    req_valid = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    exp_cnt = exp_cnt + 16'd5;
    tests_run++;
    if (g_vec.size() !== 5) begin
      tests_failed++;
      $display("FAIL fair_count: got %0d grants expected 5", g_vec.size());
    end
    for (int i = 0; i < 5 && i < g_vec.size(); i++) begin
      logic [3:0] exp_vec;
      exp_vec = 4'b0001 << (i % 4);
      tests_run++;
      if (g_vec[i] !== exp_vec) begin
        tests_failed++;
        $display("FAIL fair_order[%0d]: got %b expected %b", i, g_vec[i], exp_vec);
      end
      if (i > 0) begin
        tests_run++;
        if (g_cyc[i] - g_cyc[i-1] !== 3) begin
          tests_failed++;
          $display("FAIL fair_spacing[%0d]: got %0d cycles expected 3", i, g_cyc[i] - g_cyc[i-1]);
        end
      end
    end
    tests_run++;
    if (txn_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL fair_cnt: got %0d expected %0d", txn_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_req(2, 4'd9, 4'd5);
    rsp_ready = 1'b0; #1;
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL bp_accept: got %b expected 0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk); #1;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 5'h0E || rsp_id !== 2'd2) begin
      tests_failed++;
      $display("FAIL bp_rsp: got valid=%b sum=%h id=%0d expected 1/0e/2", rsp_valid, rsp_sum, rsp_id);
    end
    req_valid = 4'hF;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk); #1;
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 5'h0E || rsp_id !== 2'd2 ||
          req_ready !== 4'b0000 || txn_cnt !== exp_cnt) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got valid=%b sum=%h id=%0d ready=%b cnt=%0d expected 1/0e/2/0000/%0d",
                 h, rsp_valid, rsp_sum, rsp_id, req_ready, txn_cnt, exp_cnt);
      end
    end
    @(negedge clk);
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    exp_cnt++;
    tests_run++;
    if (rsp_valid !== 1'b0 || txn_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL bp_release: got valid=%b cnt=%0d expected 0/%0d", rsp_valid, txn_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_in_flight();
    @(negedge clk);
    set_req(3, 4'd2, 4'd3);
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk); #1;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 5'h05 || rsp_id !== 2'd3) begin
      tests_failed++;
      $display("FAIL rst_pre: got valid=%b sum=%h id=%0d expected 1/05/3", rsp_valid, rsp_sum, rsp_id);
    end
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'hF; #1;
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rst_ready_gate: got %b expected 0000", req_ready);
    end
    @(negedge clk);
    rst = 1'b0; #1;
    exp_cnt = 16'd0;
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_sum !== 5'h00 || txn_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL rst_resp: got valid=%b busy=%b sum=%h cnt=%0d expected 0/0/00/0",
               rsp_valid, busy, rsp_sum, txn_cnt);
    end
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rst_ptr: got %b expected 0001", req_ready);
    end
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    // Reset while the transaction is in EXEC.
    @(negedge clk);
    set_req(1, 4'd1, 4'd1);
    @(negedge clk);
    req_valid = 4'h0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || txn_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL rst_exec: got valid=%b busy=%b cnt=%0d expected 0/0/0", rsp_valid, busy, txn_cnt);
    end
  endtask

  task automatic test_idle_no_req();
    @(negedge clk);
    set_req(1, 4'd4, 4'd4);
    rsp_ready = 1'b1; #1;
    tests_run++;
    if (req_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL idle_first: got %b expected 0010", req_ready);
    end
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk);
    @(negedge clk);
    exp_cnt++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      tests_run++;
      if (busy !== 1'b0 || req_ready !== 4'b0000) begin
        tests_failed++;
        $display("FAIL idle_stay[%0d]: got busy=%b ready=%b expected 0/0000", c, busy, req_ready);
      end
    end
    req_valid = 4'hF; #1;
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL idle_ptr_kept: got %b expected 0100", req_ready);
    end
    req_valid = 4'h0;
  endtask

  task automatic test_drop();
    @(negedge clk);
    set_req(0, 4'd1, 4'd1); #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL drop_accept: got %b expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'h0;
    set_req(1, 4'd7, 4'd7);
    @(negedge clk); #1;
    tests_run++;
    if (rsp_sum !== 5'h02 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL drop_rsp: got sum=%h id=%0d ready=%b expected 02/0/0000", rsp_sum, rsp_id, req_ready);
    end
    req_valid = 4'h0;
    exp_cnt++;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      tests_run++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || txn_cnt !== exp_cnt) begin
        tests_failed++;
        $display("FAIL drop_idle[%0d]: got busy=%b valid=%b cnt=%0d expected 0/0/%0d",
                 c, busy, rsp_valid, txn_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.txn_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.txn_cnt_q;
    #1;
    tests_run++;
    if (txn_cnt !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL wrap_preload: got %h expected ffff", txn_cnt);
    end
    @(negedge clk);
    set_req(0, 4'h5, 4'hA);
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk); #1;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 5'h0F) begin
      tests_failed++;
      $display("FAIL wrap_rsp: got valid=%b sum=%h expected 1/0f", rsp_valid, rsp_sum);
    end
    @(negedge clk); #1;
    tests_run++;
    if (txn_cnt !== 16'h0000) begin
      tests_failed++;
      $display("FAIL wrap_cnt: got %h expected 0000", txn_cnt);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_cnt      = 16'd0;
    rst          = 1'b1;
    req_valid    = 4'h0;
    req_a        = 16'h0;
    req_b        = 16'h0;
    rsp_ready    = 1'b1;

    test_reset();
    test_single();
    test_max_operands();
    test_fairness();
    test_backpressure();
    test_reset_in_flight();
    test_idle_no_req();
    test_drop();
    test_wrap();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
